// File: rtl/product_accumulator.sv
// product_accumulator: sums a burst of 8-bit multiplier products into a
// saturating ACC_W-bit accumulator, then presents the sum over valid/ready.
module product_accumulator #(
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [7:0]       p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic             sat_r;
    // One extra bit so len=0 can hold the full 2^LEN_W count.
    logic [LEN_W:0]   remaining;

    logic             xfer;
    logic             last;
    logic [ACC_W:0]   sum;
    logic [LEN_W:0]   len_cnt;

    assign xfer    = p_valid && (state == ACC);
    assign last    = (remaining == {{LEN_W{1'b0}}, 1'b1});
    // Carry bit of the widened sum flags overflow past 2^ACC_W-1.
    assign sum     = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, p_in};
    assign len_cnt = (len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, len};

    // Outputs decode from state only so p_ready never depends on p_valid.
    assign p_ready   = (state == ACC);
    assign out_valid = (state == DONE);
    assign busy      = (state == ACC) || (state == DONE);
    assign acc_out   = acc;
    assign sat       = sat_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start is honoured only in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)            state_nxt = ACC;
            ACC:  if (xfer && last)     state_nxt = DONE;
            DONE: if (out_ready)        state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Datapath: clear on accepted start, accumulate with saturation on transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            sat_r     <= 1'b0;
            remaining <= '0;
        end else if (state == IDLE && start) begin
            acc       <= '0;
            sat_r     <= 1'b0;
            remaining <= len_cnt;
        end else if (xfer) begin
            remaining <= remaining - 1'b1;
            if (sum[ACC_W]) begin
                acc   <= '1;
                sat_r <= 1'b1;
            end else begin
                acc   <= sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench: a 16-bit instance for normal bursts and a
// 10-bit instance to reach saturation.
module tb_product_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic        start_a = 0, p_valid_a = 0, out_ready_a = 0;
    logic [3:0]  len_a = 0;
    logic [7:0]  p_in_a = 0;
    logic        p_ready_a, sat_a, out_valid_a, busy_a;
    logic [15:0] acc_a;

    // 10-bit instance signals
    logic        start_b = 0, p_valid_b = 0, out_ready_b = 0;
    logic [3:0]  len_b = 0;
    logic [7:0]  p_in_b = 0;
    logic        p_ready_b, sat_b, out_valid_b, busy_b;
    logic [9:0]  acc_b;

    int tests = 0;
    int fails = 0;

    product_accumulator #(.ACC_W(16), .LEN_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .len(len_a),
        .p_in(p_in_a), .p_valid(p_valid_a), .p_ready(p_ready_a),
        .acc_out(acc_a), .sat(sat_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .busy(busy_a)
    );

    product_accumulator #(.ACC_W(10), .LEN_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .len(len_b),
        .p_in(p_in_b), .p_valid(p_valid_b), .p_ready(p_ready_b),
        .acc_out(acc_b), .sat(sat_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_acc",       acc_a, 0);
        chk("rst_sat",       sat_a, 0);
        chk("rst_p_ready",   p_ready_a, 0);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_busy",      busy_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_p_ready", p_ready_a, 0);

        // 1: basic burst len=3, products 225,6,0
        start_a = 1; len_a = 4'd3;
        tick();
        start_a = 0;
        chk("s1_busy",    busy_a, 1);
        chk("s1_p_ready", p_ready_a, 1);
        p_valid_a = 1; p_in_a = 8'd225; tick();
        p_in_a = 8'd6;  tick();
        chk("s1_mid_acc",   acc_a, 231);
        chk("s1_mid_valid", out_valid_a, 0);
        p_in_a = 8'd0;  tick();
        p_valid_a = 0;
        chk("s1_out_valid", out_valid_a, 1);
        chk("s1_acc",       acc_a, 231);
        chk("s1_sat",       sat_a, 0);
        chk("s1_p_ready",   p_ready_a, 0);

        // 3: backpressure with an ignored start in DONE
        for (int i = 0; i < 10; i++) begin
            start_a = (i == 4);
            len_a   = 4'd2;
            tick();
        end
        start_a = 0;
        chk("s3_out_valid", out_valid_a, 1);
        chk("s3_acc",       acc_a, 231);
        chk("s3_busy",      busy_a, 1);
        out_ready_a = 1; tick();
        out_ready_a = 0;
        chk("s3_idle_valid", out_valid_a, 0);
        chk("s3_idle_busy",  busy_a, 0);
        chk("s3_idle_acc",   acc_a, 231);
        tick();
        chk("s3_stay_idle",  busy_a, 0);

        // 2: len=0 -> 16 products of 225, p_valid toggling
        start_a = 1; len_a = 4'd0; tick();
        start_a = 0;
        p_in_a = 8'd225;
        for (int i = 0; i < 31; i++) begin
            p_valid_a = (i % 2 == 0);
            tick();
            if (i == 28) begin
                chk("s2_mid_acc",   acc_a, 15 * 225);
                chk("s2_mid_valid", out_valid_a, 0);
            end
        end
        p_valid_a = 0;
        chk("s2_out_valid", out_valid_a, 1);
        chk("s2_acc",       acc_a, 3600);
        chk("s2_sat",       sat_a, 0);
        out_ready_a = 1; tick();
        out_ready_a = 0;
        chk("s2_idle", busy_a, 0);

        // 6: start pulsed during ACC is ignored
        start_a = 1; len_a = 4'd2; tick();
        p_valid_a = 1; p_in_a = 8'd10; start_a = 1; len_a = 4'd5; tick();
        start_a = 0; p_in_a = 8'd20; tick();
        p_valid_a = 0;
        chk("s6_out_valid", out_valid_a, 1);
        chk("s6_acc",       acc_a, 30);
        out_ready_a = 1; tick();
        out_ready_a = 0;
        chk("s6_idle", busy_a, 0);

        // 5: asynchronous reset mid-burst
        start_a = 1; len_a = 4'd4; tick();
        start_a = 0;
        p_valid_a = 1; p_in_a = 8'd100; tick();
        p_in_a = 8'd50; tick();
        p_valid_a = 0;
        chk("s5_pre_acc", acc_a, 150);
        #2 rst_n = 1'b0;
        #1;
        chk("s5_rst_acc",       acc_a, 0);
        chk("s5_rst_p_ready",   p_ready_a, 0);
        chk("s5_rst_busy",      busy_a, 0);
        chk("s5_rst_out_valid", out_valid_a, 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_a = 1; len_a = 4'd1; tick();
        start_a = 0;
        p_valid_a = 1; p_in_a = 8'd9; tick();
        p_valid_a = 0;
        chk("s5_out_valid", out_valid_a, 1);
        chk("s5_acc",       acc_a, 9);
        out_ready_a = 1; tick();
        out_ready_a = 0;

        // 4: saturation on the 10-bit instance
        start_b = 1; len_b = 4'd5; tick();
        start_b = 0;
        p_valid_b = 1; p_in_b = 8'd225;
        for (int i = 0; i < 4; i++) tick();
        chk("s4_pre_acc", acc_b, 900);
        chk("s4_pre_sat", sat_b, 0);
        tick();
        p_valid_b = 0;
        chk("s4_out_valid", out_valid_b, 1);
        chk("s4_acc",       acc_b, 1023);
        chk("s4_sat",       sat_b, 1);
        out_ready_b = 1; tick();
        out_ready_b = 0;
        chk("s4_idle_sat", sat_b, 1);
        start_b = 1; len_b = 4'd1; tick();
        start_b = 0;
        chk("s4_clr_sat", sat_b, 0);
        chk("s4_clr_acc", acc_b, 0);
        p_valid_b = 1; p_in_b = 8'd7; tick();
        p_valid_b = 0;
        chk("s4_acc2",  acc_b, 7);
        chk("s4_sat2",  sat_b, 0);
        chk("s4_valid2", out_valid_b, 1);
        out_ready_b = 1; tick();
        out_ready_b = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
